// File: rtl/bc_skid_buf_pkg.sv
// ZionBasicCircuitLib -- shared types for the basic-circuit library.
//   skidState_e : occupancy state of a 2-entry skid buffer (EMPTY/ONE/FULL)
//   skidCnt_t   : 2-bit occupancy count, 0..2
//   stateCnt()  : maps a skid state onto its occupancy count
package ZionBasicCircuitLib;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skidState_e;

  typedef logic [1:0] skidCnt_t;

  function automatic skidCnt_t stateCnt(input skidState_e s);
    case (s)
      ONE:     return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/bc_skid_buf_dff.sv
// BcEnRspDff -- enable register with a parameterised reset value.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, loads RST_VAL
//   en   : load enable
//   d    : data in
//   q    : registered data out
module BcEnRspDff #(
  parameter int              WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/bc_skid_buf.sv
// bc_skid_buf -- 2-entry skid buffer with fully registered outputs.
//   MAIN drives oDat; SKID catches the one word accepted while the
//   downstream side is stalled. All handshake outputs are registers, so
//   there is no combinational path from iVld/iDat/iRdy to any output.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   iVld/oRdy/iDat: upstream handshake and payload
//   oVld/iRdy/oDat: downstream handshake and payload
//   oCnt          : occupancy 0..2
module bc_skid_buf
  import ZionBasicCircuitLib::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] INI_DATA = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iVld,
  output logic             oRdy,
  input  logic [WIDTH-1:0] iDat,
  output logic             oVld,
  input  logic             iRdy,
  output logic [WIDTH-1:0] oDat,
  output skidCnt_t         oCnt
);

  skidState_e       state, stateNxt;
  logic             upXfer, dnXfer;
  logic             mainEn, skidEn;
  logic [WIDTH-1:0] mainD, skidD, mainQ, skidQ;

  assign upXfer = iVld && oRdy;
  assign dnXfer = oVld && iRdy;

  // Next state plus register enables/data for MAIN and SKID.
  always_comb begin
    stateNxt = state;
    mainEn   = 1'b0;
    mainD    = iDat;
    skidEn   = 1'b0;
    skidD    = iDat;
    case (state)
      EMPTY: begin
        if (upXfer) begin
          stateNxt = ONE;
          mainEn   = 1'b1;
        end
      end
      ONE: begin
        case ({upXfer, dnXfer})
          2'b10: begin
            stateNxt = FULL;
            skidEn   = 1'b1;
          end
          2'b01: begin
            stateNxt = EMPTY;
            mainEn   = 1'b1;
            mainD    = INI_DATA;
          end
          2'b11: begin
            // pop and push together: new word goes straight into MAIN
            mainEn = 1'b1;
          end
          default: ;
        endcase
      end
      FULL: begin
        // oRdy is low here, so only the downstream side can move
        if (dnXfer) begin
          stateNxt = ONE;
          mainEn   = 1'b1;
          mainD    = skidQ;
          skidEn   = 1'b1;
          skidD    = INI_DATA;
        end
      end
      default: stateNxt = EMPTY;
    endcase
  end

  // Outputs are registered from the next state, so they track state exactly
  // while staying free of input-to-output paths. oRdy comes out of reset low
  // and rises on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      oRdy  <= 1'b0;
      oVld  <= 1'b0;
      oCnt  <= 2'd0;
    end else begin
      state <= stateNxt;
      oRdy  <= (stateNxt != FULL);
      oVld  <= (stateNxt != EMPTY);
      oCnt  <= stateCnt(stateNxt);
    end
  end

  BcEnRspDff #(.WIDTH(WIDTH), .RST_VAL(INI_DATA)) uMain (
    .clk (clk),
    .rst (rst),
    .en  (mainEn),
    .d   (mainD),
    .q   (mainQ)
  );

  BcEnRspDff #(.WIDTH(WIDTH), .RST_VAL(INI_DATA)) uSkid (
    .clk (clk),
    .rst (rst),
    .en  (skidEn),
    .d   (skidD),
    .q   (skidQ)
  );

  assign oDat = mainQ;

endmodule

// File: tb/tb_bc_skid_buf.sv
// Self-checking bench for bc_skid_buf: directed scenarios followed by a
// random stream, checked against a queue-based reference model.
module tb_bc_skid_buf;

  localparam int          W   = 32;
  localparam logic [31:0] INI = 32'h1;

  logic         clk = 1'b0;
  logic         rst;
  logic         iVld, oRdy, oVld, iRdy;
  logic [W-1:0] iDat, oDat;
  logic [1:0]   oCnt;

  bc_skid_buf #(.WIDTH(W), .INI_DATA(INI)) dut (
    .clk  (clk),
    .rst  (rst),
    .iVld (iVld),
    .oRdy (oRdy),
    .iDat (iDat),
    .oVld (oVld),
    .iRdy (iRdy),
    .oDat (oDat),
    .oCnt (oCnt)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nMis = 0;

  // Reference model: a FIFO of accepted words plus the ready flag the
  // buffer should be presenting. Ready is low during reset and for the
  // remainder of the cycle in which reset is released.
  logic [W-1:0] expQ[$];
  logic         mRdy = 1'b0;
  logic         streamPhase = 1'b0;

  always @(posedge rst) begin
    expQ.delete();
    mRdy = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      expQ.delete();
      mRdy = 1'b0;
    end else begin
      if (iRdy && expQ.size() > 0) void'(expQ.pop_front());
      if (iVld && mRdy) expQ.push_back(iDat);
      mRdy = (expQ.size() < 2);
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every falling edge compare all outputs to the model.
  always @(negedge clk) begin
    if (rst !== 1'bx) begin
      chk("oVld", W'(oVld), W'(expQ.size() > 0));
      chk("oRdy", W'(oRdy), W'(mRdy));
      chk("oCnt", W'(oCnt), W'(expQ.size()));
      chk("oDat", oDat, (expQ.size() > 0) ? expQ[0] : INI);
      if (streamPhase) chk("streamCnt<=1", W'(oCnt <= 2'd1), W'(1));
    end
  end

  // Apply one cycle of stimulus, driven well after the rising edge.
  task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
    iVld = v;
    iDat = d;
    iRdy = r;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst  = 1'b1;
    iVld = 1'b0;
    iDat = '0;
    iRdy = 1'b0;
    repeat (3) drive(1'b0, '0, 1'b0);
    rst = 1'b0;
    // ready must still be low until the first edge after release
    #1 chk("oRdyAtRelease", W'(oRdy), W'(0));
    drive(1'b0, '0, 1'b0);

    // Stream: one word per cycle, each visible one cycle after acceptance.
    streamPhase = 1'b1;
    for (int i = 0; i < 8; i++) drive(1'b1, 32'hA0 + 32'(i), 1'b1);
    drive(1'b0, '0, 1'b1);
    streamPhase = 1'b0;
    drive(1'b0, '0, 1'b1);

    // Stall: fill both entries, offer a third that must be refused.
    drive(1'b1, 32'h11, 1'b0);
    drive(1'b1, 32'h22, 1'b0);
    drive(1'b1, 32'h33, 1'b0);
    chk("stallCnt", W'(oCnt), W'(2));
    chk("stallRdy", W'(oRdy), W'(0));
    drive(1'b1, 32'h33, 1'b0);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1);
    drive(1'b1, 32'h33, 1'b1);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1);

    // Simultaneous push and pop with one word held.
    drive(1'b1, 32'h5, 1'b0);
    chk("mainIs5", oDat, 32'h5);
    drive(1'b1, 32'h6, 1'b1);
    chk("simulDat", oDat, 32'h6);
    chk("simulCnt", W'(oCnt), W'(1));
    drive(1'b0, '0, 1'b1);

    // Reset mid-stream with two words held.
    drive(1'b1, 32'h77, 1'b0);
    drive(1'b1, 32'h88, 1'b0);
    chk("preRstCnt", W'(oCnt), W'(2));
    rst = 1'b1;
    #1;
    chk("rstVld", W'(oVld), W'(0));
    chk("rstCnt", W'(oCnt), W'(0));
    chk("rstDat", oDat, INI);
    chk("rstRdy", W'(oRdy), W'(0));
    drive(1'b1, 32'h99, 1'b1);
    drive(1'b1, 32'h99, 1'b1);
    rst = 1'b0;
    drive(1'b0, '0, 1'b0);
    chk("rdyAfterRelease", W'(oRdy), W'(1));

    // Random traffic.
    for (int i = 0; i < 2000; i++)
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0 ? 1 : 0) & 1'($urandom_range(0, 1) | (i[8])));
    // Drain.
    repeat (4) drive(1'b0, '0, 1'b1);
    chk("drained", W'(oCnt), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
